// File: rtl/pie_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// pie_rx_frame_ctrl_if
// Bundles the two buses of the PIE receive frame controller:
//   decoder side : dec_bit, dec_valid, dec_sync (from decoder), dec_rst (to it)
//   frame side   : frame_data, frame_len, frame_valid (to consumer),
//                  frame_ready (from consumer)
// master = the frame controller, slave = decoder/command-layer side.
// ---------------------------------------------------------------------------
interface pie_rx_frame_ctrl_if #(
  parameter int MAX_BITS = 64,
  parameter int LW       = $clog2(MAX_BITS + 1)
);
  logic                dec_bit;
  logic                dec_valid;
  logic                dec_sync;
  logic                dec_rst;
  logic [MAX_BITS-1:0] frame_data;
  logic [LW-1:0]       frame_len;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    input  dec_bit, dec_valid, dec_sync, frame_ready,
    output dec_rst, frame_data, frame_len, frame_valid
  );

  modport slave (
    output dec_bit, dec_valid, dec_sync, frame_ready,
    input  dec_rst, frame_data, frame_len, frame_valid
  );
endinterface

// File: rtl/pie_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pie_rx_frame_ctrl
// Receive-side frame controller for the PIE decoder. Re-arms the decoder via
// dec_rst, waits for frame sync, shifts decoded bits into a right-aligned
// buffer, closes the frame on sync loss or inter-bit idle timeout, checks
// min/max length and offers the frame on a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_enable          level, permits reception
//   bus (master)      decoder strobes/sync in, dec_rst out,
//                     frame_data/len/valid out, frame_ready in
//   o_err_overflow    1-cycle pulse, bit arrived with buffer full
//   o_err_short       1-cycle pulse, frame closed shorter than MIN_BITS
//   o_busy            high while collecting or holding a frame
// ---------------------------------------------------------------------------
module pie_rx_frame_ctrl #(
  parameter int MAX_BITS     = 64,
  parameter int MIN_BITS     = 4,
  parameter int EOF_IDLE     = 24,
  parameter int REARM_CYCLES = 2,
  parameter int LW           = $clog2(MAX_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  pie_rx_frame_ctrl_if.master   bus,
  output logic                  o_err_overflow,
  output logic                  o_err_short,
  output logic                  o_busy
);

  localparam int IW = $clog2(EOF_IDLE + 1);
  localparam int AW = $clog2(REARM_CYCLES + 1);

  typedef enum logic [1:0] {
    S_ARM       = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_COLLECT   = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_arm_cnt, w_arm_nxt;
  logic [IW-1:0]       r_idle, w_idle_nxt;
  logic [MAX_BITS-1:0] r_data, w_data_nxt;
  logic [LW-1:0]       r_len, w_len_nxt;
  logic                r_dec_rst, w_dec_rst_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                r_short, w_short_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_ARM;
      r_arm_cnt <= '0;
      r_idle    <= '0;
      r_data    <= '0;
      r_len     <= '0;
      r_dec_rst <= 1'b1;
      r_ovf     <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm_cnt <= w_arm_nxt;
      r_idle    <= w_idle_nxt;
      r_data    <= w_data_nxt;
      r_len     <= w_len_nxt;
      r_dec_rst <= w_dec_rst_nxt;
      r_ovf     <= w_ovf_nxt;
      r_short   <= w_short_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_nxt   = r_arm_cnt;
    w_idle_nxt  = r_idle;
    w_data_nxt  = r_data;
    w_len_nxt   = r_len;
    w_ovf_nxt   = 1'b0;
    w_short_nxt = 1'b0;

    case (r_state)
      S_ARM: begin
        // Counter saturates so a long enable=0 stall still leaves the
        // re-arm window complete when enable returns.
        if (r_arm_cnt != AW'(REARM_CYCLES))
          w_arm_nxt = r_arm_cnt + AW'(1);
        // ARM occupies exactly REARM_CYCLES cycles when enable is high.
        if (i_enable && (r_arm_cnt >= AW'(REARM_CYCLES - 1)))
          w_state_nxt = S_WAIT_SYNC;
      end

      S_WAIT_SYNC: begin
        if (!i_enable) begin
          w_state_nxt = S_ARM;
        end else if (bus.dec_sync) begin
          w_data_nxt  = '0;
          w_len_nxt   = '0;
          w_idle_nxt  = '0;
          w_state_nxt = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (!i_enable) begin
          w_state_nxt = S_ARM;
        end else if (bus.dec_valid && (r_len == LW'(MAX_BITS))) begin
          w_ovf_nxt   = 1'b1;
          w_state_nxt = S_ARM;
        end else begin
          if (bus.dec_valid) begin
            w_data_nxt = {r_data[MAX_BITS-2:0], bus.dec_bit};
            w_len_nxt  = r_len + LW'(1);
            w_idle_nxt = '0;
          end else if (r_idle != IW'(EOF_IDLE)) begin
            w_idle_nxt = r_idle + IW'(1);
          end
          // End test uses post-update length/idle so a bit landing on the
          // sync-drop cycle still counts toward the frame.
          if (!bus.dec_sync || (w_idle_nxt == IW'(EOF_IDLE))) begin
            if (w_len_nxt >= LW'(MIN_BITS)) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_short_nxt = 1'b1;
              w_state_nxt = S_ARM;
            end
          end
        end
      end

      S_HOLD: begin
        if (bus.frame_ready)
          w_state_nxt = S_ARM;
      end

      default: w_state_nxt = S_ARM;
    endcase

    // Every entry into ARM starts a fresh re-arm window.
    if ((w_state_nxt == S_ARM) && (r_state != S_ARM))
      w_arm_nxt = '0;

    // Decoder is held in reset while arming and while a frame awaits pickup.
    w_dec_rst_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_HOLD);
  end

  assign bus.dec_rst     = r_dec_rst;
  assign bus.frame_data  = r_data;
  assign bus.frame_len   = r_len;
  assign bus.frame_valid = (r_state == S_HOLD);
  assign o_err_overflow  = r_ovf;
  assign o_err_short     = r_short;
  assign o_busy          = (r_state == S_COLLECT) || (r_state == S_HOLD);

endmodule

// File: tb/tb_pie_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pie_rx_frame_ctrl
// Table-driven vectors, directed multi-cycle sequences and a randomized run
// checked against a queue-based behavioural model of the frame controller.
// ---------------------------------------------------------------------------
module tb_pie_rx_frame_ctrl;
  localparam int MAX_BITS = 64;
  localparam int MIN_BITS = 4;
  localparam int EOF_IDLE = 24;
  localparam int REARM    = 2;

  localparam int M_ARM  = 0;
  localparam int M_WAIT = 1;
  localparam int M_COLL = 2;
  localparam int M_HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic err_ovf, err_short, busy;

  pie_rx_frame_ctrl_if #(.MAX_BITS(MAX_BITS)) bus ();

  pie_rx_frame_ctrl #(
    .MAX_BITS(MAX_BITS), .MIN_BITS(MIN_BITS),
    .EOF_IDLE(EOF_IDLE), .REARM_CYCLES(REARM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .bus(bus),
    .o_err_overflow(err_ovf), .o_err_short(err_short), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic en, v, b, s, r;
    logic x_rst, x_vld, x_busy, x_ovf, x_short;
    int   x_len;   // -1: not checked
    longint x_data; // -1: not checked
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  int   m_mode;
  int   m_left;
  int   m_quiet;
  bit   m_ovf, m_short;
  bit   q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string nm, input logic x_rst, input logic x_vld,
                            input logic x_busy, input logic x_ovf, input logic x_short);
    chk({nm, ".dec_rst"}, 64'(bus.dec_rst), 64'(x_rst));
    chk({nm, ".frame_valid"}, 64'(bus.frame_valid), 64'(x_vld));
    chk({nm, ".busy"}, 64'(busy), 64'(x_busy));
    chk({nm, ".err_overflow"}, 64'(err_ovf), 64'(x_ovf));
    chk({nm, ".err_short"}, 64'(err_short), 64'(x_short));
  endtask

  task automatic cyc(input logic en, input logic v, input logic b, input logic s, input logic r);
    enable = en;
    bus.dec_valid = v;
    bus.dec_bit = b;
    bus.dec_sync = s;
    bus.frame_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic v, input logic b, input logic s,
                              input logic r, input logic x_rst, input logic x_vld,
                              input logic x_busy, input logic x_ovf, input logic x_short,
                              input int x_len, input longint x_data);
    vec_t t;
    t.en = en; t.v = v; t.b = b; t.s = s; t.r = r;
    t.x_rst = x_rst; t.x_vld = x_vld; t.x_busy = x_busy;
    t.x_ovf = x_ovf; t.x_short = x_short;
    t.x_len = x_len; t.x_data = x_data;
    return t;
  endfunction

  task automatic model_reset();
    m_mode = M_ARM;
    m_left = REARM;
    m_quiet = 0;
    m_ovf = 1'b0;
    m_short = 1'b0;
    q.delete();
  endtask

  task automatic model_to_arm();
    m_mode = M_ARM;
    m_left = REARM;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input bit en, input bit v, input bit b, input bit s, input bit r);
    m_ovf = 1'b0;
    m_short = 1'b0;
    case (m_mode)
      M_ARM: begin
        if (m_left > 0) m_left--;
        if (m_left == 0 && en) m_mode = M_WAIT;
      end
      M_WAIT: begin
        if (!en) model_to_arm();
        else if (s) begin
          q.delete();
          m_quiet = 0;
          m_mode = M_COLL;
        end
      end
      M_COLL: begin
        if (!en) model_to_arm();
        else if (v && q.size() == MAX_BITS) begin
          m_ovf = 1'b1;
          model_to_arm();
        end else begin
          if (v) begin
            q.push_back(b);
            m_quiet = 0;
          end else if (m_quiet < EOF_IDLE) m_quiet++;
          if (!s || m_quiet == EOF_IDLE) begin
            if (q.size() >= MIN_BITS) m_mode = M_HOLD;
            else begin
              m_short = 1'b1;
              model_to_arm();
            end
          end
        end
      end
      default: if (r) model_to_arm();
    endcase
  endtask

  function automatic logic [63:0] model_data();
    logic [63:0] d;
    int n;
    d = '0;
    n = q.size();
    for (int i = 0; i < n; i++)
      if (q[i]) d[n-1-i] = 1'b1;
    return d;
  endfunction

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.frame_len", 64'(bus.frame_len), 64'd0);
    chk("reset.frame_data", bus.frame_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic go_collect();
    int k;
    k = 0;
    while (bus.dec_rst !== 1'b0 && k < 10) begin
      cyc(1, 0, 0, 0, 0);
      k++;
    end
    chk("arm_timeout", 64'(bus.dec_rst), 64'd0);
    cyc(1, 0, 0, 1, 0);
    chk("sync.busy", 64'(busy), 64'd1);
    chk("sync.len", 64'(bus.frame_len), 64'd0);
  endtask

  initial begin
    logic [7:0] nom;
    logic [2:0] col;
    int vprob, tprob;
    bit rs, ren, rv, rb, rr;

    enable = 1'b0;
    bus.dec_bit = 1'b0;
    bus.dec_valid = 1'b0;
    bus.dec_sync = 1'b0;
    bus.frame_ready = 1'b0;
    do_reset();

    // ---- table: nominal frame, short frame, collision at len 3 ----
    nom = 8'b1011_0010;
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,1,0, 0,0,1,0,0, 0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1,1,nom[7-i],1,0, 0,0,1,0,0, i+1,-1));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,0,0, 8,64'hB2));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,0,0, 8,64'hB2));
    tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,1,0, 0,0,1,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0, 0,0,1,0,0, 1,-1));
    tbl.push_back(mk(1,1,0,1,0, 0,0,1,0,0, 2,-1));
    tbl.push_back(mk(1,1,1,1,0, 0,0,1,0,0, 3,-1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,1, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,1,0, 0,0,1,0,0, 0,0));
    col = 3'b110;
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,col[2-i],1,(i == 2), 0,0,1,0,0, i+1,-1));
    tbl.push_back(mk(1,1,1,0,1, 1,1,1,0,0, 4,64'hD));
    tbl.push_back(mk(1,0,0,0,1, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0, -1,-1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, -1,-1));

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].r);
      chk_status($sformatf("row%0d", i), tbl[i].x_rst, tbl[i].x_vld, tbl[i].x_busy,
                 tbl[i].x_ovf, tbl[i].x_short);
      if (tbl[i].x_len >= 0)
        chk($sformatf("row%0d.len", i), 64'(bus.frame_len), 64'(tbl[i].x_len));
      if (tbl[i].x_data >= 0)
        chk($sformatf("row%0d.data", i), bus.frame_data, 64'(tbl[i].x_data));
    end

    // ---- idle timeout: 5 bits then 24 quiet cycles ----
    go_collect();
    for (int i = 0; i < 5; i++) cyc(1, 1, i[0], 1, 0);
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 0, 0, 1, 0);
      chk($sformatf("idle.q%0d", k), 64'(bus.frame_valid), 64'(k == 24));
    end
    chk("idle.len", 64'(bus.frame_len), 64'd5);
    chk("idle.data", bus.frame_data, 64'h0A);
    cyc(1, 0, 0, 1, 1);
    chk_status("idle.ack", 1, 0, 0, 0, 0);

    // ---- idle timeout restarted by a bit on quiet cycle 23 ----
    go_collect();
    for (int i = 0; i < 5; i++) cyc(1, 1, i[0], 1, 0);
    for (int k = 1; k <= 23; k++) begin
      if (k == 23) cyc(1, 1, 1, 1, 0);
      else cyc(1, 0, 0, 1, 0);
      chk($sformatf("restart.a%0d", k), 64'(bus.frame_valid), 64'd0);
    end
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 0, 0, 1, 0);
      chk($sformatf("restart.q%0d", k), 64'(bus.frame_valid), 64'(k == 24));
    end
    chk("restart.len", 64'(bus.frame_len), 64'd6);
    chk("restart.data", bus.frame_data, 64'h15);
    cyc(1, 0, 0, 0, 1);

    // ---- overflow: 65th bit with a full buffer ----
    go_collect();
    for (int i = 0; i < MAX_BITS; i++) cyc(1, 1, (i % 3 == 0), 1, 0);
    chk("ovf.len64", 64'(bus.frame_len), 64'd64);
    chk("ovf.busy64", 64'(busy), 64'd1);
    cyc(1, 1, 1, 1, 0);
    chk_status("ovf.65th", 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("ovf.pulse_end", 64'(err_ovf), 64'd0);

    // ---- backpressure: frame frozen, decoder held in reset ----
    go_collect();
    col = 3'b111;
    for (int i = 0; i < 6; i++) cyc(1, 1, (i < 3 || i == 5), 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("bp.valid", 64'(bus.frame_valid), 64'd1);
    for (int k = 0; k < 50; k++) begin
      cyc((k % 7 != 0), 1, 1'($urandom), 1'($urandom), 0);
      chk($sformatf("bp.data%0d", k), bus.frame_data, 64'h39);
      chk($sformatf("bp.rst%0d", k), {62'd0, bus.dec_rst, bus.frame_valid}, 64'd3);
    end
    chk("bp.len", 64'(bus.frame_len), 64'd6);
    cyc(1, 0, 0, 0, 1);
    chk_status("bp.ack", 1, 0, 0, 0, 0);

    // ---- enable drop mid-COLLECT ----
    go_collect();
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk_status("abort", 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1, 1, 0);
      chk_status($sformatf("abort.hold%0d", k), 1, 0, 0, 0, 0);
    end

    // ---- asynchronous reset mid-COLLECT ----
    go_collect();
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    chk("arst.pre", bus.frame_data, 64'h3);
    do_reset();

    // ---- randomized run against the model ----
    vprob = 2;
    tprob = 30;
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        continue;
      end
      if (i % 50 == 0) begin
        vprob = ($urandom_range(0, 1) == 0) ? 2 : 10;
        tprob = ($urandom_range(0, 1) == 0) ? 8 : 100;
      end
      if ($urandom_range(0, tprob - 1) == 0) rs = ~rs;
      ren = ($urandom_range(0, 199) != 0);
      rv  = ($urandom_range(0, vprob - 1) == 0);
      rb  = 1'($urandom);
      rr  = ($urandom_range(0, 3) == 0);
      model_step(ren, rv, rb, rs, rr);
      cyc(ren, rv, rb, rs, rr);
      chk_status($sformatf("rnd%0d", i), (m_mode == M_ARM || m_mode == M_HOLD),
                 (m_mode == M_HOLD), (m_mode == M_COLL || m_mode == M_HOLD), m_ovf, m_short);
      if (m_mode == M_HOLD) begin
        chk($sformatf("rnd%0d.len", i), 64'(bus.frame_len), 64'(q.size()));
        chk($sformatf("rnd%0d.data", i), bus.frame_data, model_data());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
